// File: rtl/tt_cell_pad_ctrl.sv
// Per-lane pad front-end: serial config shadow/active registers, registered pad
// controls, synchronised and optionally filtered pad input with edge pulses.
// Optional rising-edge counter is enabled by defining TT_PAD_EDGECNT_EN.
module tt_cell_pad_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_sdi,
  input  logic       cfg_sen,
  input  logic       cfg_latch,
  output logic       cfg_sdo,
  input  logic       out_val,
  input  logic       out_oe_req,
  output logic       in_val,
  output logic       in_rise,
  output logic       in_fall,
  input  logic       pad_Y,
  output logic       pad_A,
  output logic       pad_OE,
  output logic       pad_IE,
  output logic       pad_SL,
  output logic       pad_CS,
  output logic       pad_PD,
  output logic       pad_PU
`ifdef TT_PAD_EDGECNT_EN
  ,
  output logic [7:0] edge_cnt
`endif
);

  localparam logic [7:0] CFG_RST  = 8'h02;
  localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);

  logic [7:0]             shadow_q, shadow_d;
  logic [7:0]             active_q, active_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]             filt_cnt_q, filt_cnt_d;
  logic                   in_val_q, in_val_d;
  logic                   in_val_dly_q;
  logic                   in_rise_q, in_fall_q;
  logic                   pad_a_q, pad_oe_q, pad_ie_q, pad_sl_q;
  logic                   pad_cs_q, pad_pd_q, pad_pu_q;

  logic cfg_oe_en, cfg_ie, cfg_sl, cfg_cs, cfg_pd, cfg_pu, cfg_inv, cfg_filt_en;
  logic sync_s;

  assign {cfg_filt_en, cfg_inv, cfg_pu, cfg_pd, cfg_cs, cfg_sl, cfg_ie, cfg_oe_en} = active_q;
  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (cfg_sen) shadow_d = {cfg_sdi, shadow_q[7:1]};
    // Latch takes the shadow as it was before any same-cycle shift.
    if (cfg_latch) active_d = shadow_q;
  end

  assign sync_d = {sync_q[SYNC_STAGES-2:0], pad_Y & cfg_ie};

  always_comb begin
    in_val_d   = in_val_q;
    filt_cnt_d = filt_cnt_q;
    if (!cfg_filt_en) begin
      in_val_d   = sync_s;
      filt_cnt_d = 4'd0;
    end else if (cfg_latch) begin
      filt_cnt_d = 4'd0;
    end else if (sync_s != in_val_q) begin
      if (filt_cnt_q == FILT_MAX) begin
        in_val_d   = sync_s;
        filt_cnt_d = 4'd0;
      end else begin
        filt_cnt_d = filt_cnt_q + 4'd1;
      end
    end else begin
      filt_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= CFG_RST;
      active_q     <= CFG_RST;
      sync_q       <= '0;
      filt_cnt_q   <= 4'd0;
      in_val_q     <= 1'b0;
      in_val_dly_q <= 1'b0;
      in_rise_q    <= 1'b0;
      in_fall_q    <= 1'b0;
      pad_a_q      <= 1'b0;
      pad_oe_q     <= 1'b0;
      pad_ie_q     <= 1'b1;
      pad_sl_q     <= 1'b0;
      pad_cs_q     <= 1'b0;
      pad_pd_q     <= 1'b0;
      pad_pu_q     <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      sync_q       <= sync_d;
      filt_cnt_q   <= filt_cnt_d;
      in_val_q     <= in_val_d;
      in_val_dly_q <= in_val_q;
      in_rise_q    <= in_val_q & ~in_val_dly_q;
      in_fall_q    <= ~in_val_q & in_val_dly_q;
      pad_a_q      <= out_val ^ cfg_inv;
      pad_oe_q     <= out_oe_req & cfg_oe_en;
      pad_ie_q     <= cfg_ie;
      pad_sl_q     <= cfg_sl;
      pad_cs_q     <= cfg_cs;
      // Both pulls on at once would fight; release both instead.
      pad_pd_q     <= cfg_pd & ~cfg_pu;
      pad_pu_q     <= cfg_pu & ~cfg_pd;
    end
  end

`ifdef TT_PAD_EDGECNT_EN
  logic [7:0] edge_cnt_q, edge_cnt_d;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (cfg_latch) edge_cnt_d = 8'h00;
    else if (in_rise_q && edge_cnt_q != 8'hFF) edge_cnt_d = edge_cnt_q + 8'h01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt_q <= 8'h00;
    else        edge_cnt_q <= edge_cnt_d;
  end

  assign edge_cnt = edge_cnt_q;
`endif

  assign cfg_sdo = shadow_q[0];
  assign in_val  = in_val_q;
  assign in_rise = in_rise_q;
  assign in_fall = in_fall_q;
  assign pad_A   = pad_a_q;
  assign pad_OE  = pad_oe_q;
  assign pad_IE  = pad_ie_q;
  assign pad_SL  = pad_sl_q;
  assign pad_CS  = pad_cs_q;
  assign pad_PD  = pad_pd_q;
  assign pad_PU  = pad_pu_q;

endmodule

// File: tb/tb_tt_cell_pad_ctrl.sv
// Testbench for tt_cell_pad_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_tt_cell_pad_ctrl;
  localparam int SYNC = 2;
  localparam int FLEN = 4;

  logic clk = 1'b0;
  logic rst_n, cfg_sdi, cfg_sen, cfg_latch, cfg_sdo;
  logic out_val, out_oe_req, in_val, in_rise, in_fall, pad_Y;
  logic pad_A, pad_OE, pad_IE, pad_SL, pad_CS, pad_PD, pad_PU;
`ifdef TT_PAD_EDGECNT_EN
  logic [7:0] edge_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  tt_cell_pad_ctrl #(.SYNC_STAGES(SYNC), .FILT_LEN(FLEN)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_sdi(cfg_sdi), .cfg_sen(cfg_sen),
    .cfg_latch(cfg_latch), .cfg_sdo(cfg_sdo), .out_val(out_val),
    .out_oe_req(out_oe_req), .in_val(in_val), .in_rise(in_rise),
    .in_fall(in_fall), .pad_Y(pad_Y), .pad_A(pad_A), .pad_OE(pad_OE),
    .pad_IE(pad_IE), .pad_SL(pad_SL), .pad_CS(pad_CS), .pad_PD(pad_PD),
    .pad_PU(pad_PU)
`ifdef TT_PAD_EDGECNT_EN
    , .edge_cnt(edge_cnt)
`endif
  );

  // Behavioural model: config word, input delay line, filter run length.
  bit [7:0] m_shadow, m_active;
  bit       m_dline [SYNC];
  int       m_run;
  bit       m_in, m_in_prev, m_rise, m_fall;
  bit       m_A, m_OE, m_IE, m_SL, m_CS, m_PD, m_PU;
  int       m_edges;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_shadow <= 8'h02; m_active <= 8'h02;
      for (int i = 0; i < SYNC; i++) m_dline[i] <= 1'b0;
      m_run <= 0; m_in <= 0; m_in_prev <= 0; m_rise <= 0; m_fall <= 0;
      {m_A, m_OE, m_IE, m_SL, m_CS, m_PD, m_PU} <= 7'b0010000;
      m_edges <= 0;
    end else begin
      automatic bit s = m_dline[SYNC-1];
      automatic bit nin = m_in;
      automatic int nrun = m_run;
      automatic bit pu = m_active[5], pd = m_active[4];
      if (!m_active[7]) begin nin = s; nrun = 0; end
      else if (cfg_latch) nrun = 0;
      else if (s == m_in) nrun = 0;
      else if (m_run + 1 >= FLEN) begin nin = s; nrun = 0; end
      else nrun = m_run + 1;
      m_in <= nin; m_run <= nrun; m_in_prev <= m_in;
      m_rise <= m_in && !m_in_prev;
      m_fall <= !m_in && m_in_prev;
      m_dline[0] <= pad_Y & m_active[1];
      for (int i = 1; i < SYNC; i++) m_dline[i] <= m_dline[i-1];
      m_A  <= out_val ^ m_active[6];
      m_OE <= out_oe_req & m_active[0];
      m_IE <= m_active[1]; m_SL <= m_active[2]; m_CS <= m_active[3];
      m_PD <= pd && !pu;   m_PU <= pu && !pd;
      if (cfg_sen) m_shadow <= (m_shadow >> 1) | (8'(cfg_sdi) << 7);
      if (cfg_latch) m_active <= m_shadow;
      if (cfg_latch) m_edges <= 0;
      else if (m_rise) m_edges <= (m_edges < 255) ? m_edges + 1 : 255;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cfg_sdo", 8'(cfg_sdo), 8'(m_shadow[0]));
      chk("in_val",  8'(in_val),  8'(m_in));
      chk("in_rise", 8'(in_rise), 8'(m_rise));
      chk("in_fall", 8'(in_fall), 8'(m_fall));
      chk("pad_A",   8'(pad_A),   8'(m_A));
      chk("pad_OE",  8'(pad_OE),  8'(m_OE));
      chk("pad_IE",  8'(pad_IE),  8'(m_IE));
      chk("pad_SL",  8'(pad_SL),  8'(m_SL));
      chk("pad_CS",  8'(pad_CS),  8'(m_CS));
      chk("pad_PD",  8'(pad_PD),  8'(m_PD));
      chk("pad_PU",  8'(pad_PU),  8'(m_PU));
      chk("rise_fall_excl", 8'(in_rise & in_fall), 8'h00);
`ifdef TT_PAD_EDGECNT_EN
      chk("edge_cnt", edge_cnt, 8'(m_edges));
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_cfg(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      cfg_sen = 1'b1; cfg_sdi = w[i]; tick();
    end
    cfg_sen = 1'b0; cfg_sdi = 1'b0; cfg_latch = 1'b1; tick();
    cfg_latch = 1'b0;
  endtask

  initial begin
    int rises, falls;
    rst_n = 1'b0; cfg_sdi = 0; cfg_sen = 0; cfg_latch = 0;
    out_val = 0; out_oe_req = 0; pad_Y = 0;
    repeat (3) tick();
    chk("rst_pads", 8'({pad_A, pad_OE, pad_IE, pad_SL, pad_CS, pad_PD, pad_PU}), 8'b0010000);
    chk("rst_in",   8'({in_val, in_rise, in_fall, cfg_sdo}), 8'h0);
    rst_n = 1'b1; chk_en = 1;

    // Shift 0x3F and drive: OE/SL/CS on, illegal PU+PD releases both.
    out_val = 1; out_oe_req = 1;
    load_cfg(8'h3F);
    tick();
    chk("t2_pads", 8'({pad_A, pad_OE, pad_IE, pad_SL, pad_CS, pad_PD, pad_PU}), 8'b1111100);

    // Unfiltered: in_val exactly SYNC+1 cycles after pad_Y rises.
    load_cfg(8'h02);
    repeat (6) tick();
    pad_Y = 1;
    for (int c = 1; c <= SYNC + 2; c++) begin
      tick();
      if (c <= SYNC) chk("t4_in_early", 8'(in_val), 8'h0);
      if (c == SYNC + 1) chk("t4_in_set", 8'(in_val), 8'h1);
      if (c == SYNC + 2) chk("t4_rise", 8'(in_rise), 8'h1);
    end
    tick();
    chk("t4_rise_once", 8'(in_rise), 8'h0);

    // IE dropped while in_val=1: in_val falls with a single in_fall.
    load_cfg(8'h00);
    falls = 0;
    repeat (10) begin tick(); falls += int'(in_fall); end
    chk("t5_in", 8'(in_val), 8'h0);
    chk("t5_falls", 8'(falls), 8'h1);

    // Filtered: 3-cycle pulse rejected, 4-cycle pulse accepted at SYNC+4.
    pad_Y = 0;
    load_cfg(8'h82);
    repeat (8) tick();
    pad_Y = 1; repeat (3) tick(); pad_Y = 0;
    rises = 0;
    repeat (12) begin tick(); rises += int'(in_val); end
    chk("t3_short", 8'(rises), 8'h0);
    pad_Y = 1;
    rises = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 4) pad_Y = 0;
      if (c == SYNC + 3) chk("t3_in_pre", 8'(in_val), 8'h0);
      if (c == SYNC + 4) chk("t3_in_set", 8'(in_val), 8'h1);
      rises += int'(in_rise);
    end
    chk("t3_one_rise", 8'(rises), 8'h1);

`ifdef TT_PAD_EDGECNT_EN
    load_cfg(8'h02);
    repeat (300) begin
      pad_Y = 1; repeat (3) tick();
      pad_Y = 0; repeat (3) tick();
    end
    repeat (6) tick();
    chk("ec_sat", edge_cnt, 8'hFF);
    cfg_latch = 1; tick(); cfg_latch = 0;
    chk("ec_clr", edge_cnt, 8'h00);
`endif

    // Randomized traffic, including occasional mid-operation resets.
    for (int n = 0; n < 4000; n++) begin
      cfg_sen    = $urandom_range(1, 0) == 1;
      cfg_sdi    = $urandom_range(1, 0) == 1;
      cfg_latch  = $urandom_range(11, 0) == 0;
      out_val    = $urandom_range(1, 0) == 1;
      out_oe_req = $urandom_range(1, 0) == 1;
      if ($urandom_range(4, 0) == 0) pad_Y = ~pad_Y;
      if ($urandom_range(499, 0) == 0) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
      end
      tick();
    end
    cfg_sen = 0; cfg_latch = 0;
    tick();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
